// File: rtl/game_score_timer_pkg.sv
// Shared types and seven-segment constants for the game score/timer block.
// Segment bit order: {centre, upper-left, lower-left, bottom, lower-right, upper-right, top}.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/game_score_timer_if.sv
// Bundle of game control inputs and display/status outputs.
// master drives start/hit, slave is the game block side.
interface game_score_timer_if;

  logic       start;
  logic       hit;
  logic [6:0] score_tens;
  logic [6:0] score_ones;
  logic [6:0] time_seg;
  logic [7:0] score_bcd;
  logic       running;
  logic       game_over;

  modport master (
    output start,
    output hit,
    input  score_tens,
    input  score_ones,
    input  time_seg,
    input  score_bcd,
    input  running,
    input  game_over
  );

  modport slave (
    input  start,
    input  hit,
    output score_tens,
    output score_ones,
    output time_seg,
    output score_bcd,
    output running,
    output game_over
  );

endinterface

// File: rtl/game_score_timer_seg7_encoder.sv
// BCD digit to active-low seven-segment code.
// Values above 9 render blank.
module seg7_encoder
  import game_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) o_seg = SEG_DIGIT[i_bcd];
  end

endmodule

// File: rtl/game_score_timer.sv
// Two-digit BCD hit score and one-digit seconds countdown,
// driving three registered seven-segment digit buses.
module game_score_timer
  import game_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int GAME_SECONDS = 9,
  parameter int SCORE_MAX    = 99
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iStart,
  input  logic       iHit,
  output logic [6:0] oScore_tens,
  output logic [6:0] oScore_ones,
  output logic [6:0] oTime_seg,
  output logic [7:0] oScore_bcd,
  output logic       oRunning,
  output logic       oGameOver
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam bcd_t T0    = bcd_t'(GAME_SECONDS);
  localparam bcd_t MAX_T = bcd_t'(SCORE_MAX / 10);
  localparam bcd_t MAX_O = bcd_t'(SCORE_MAX % 10);
  localparam logic [6:0] SEG_T0 = SEG_DIGIT[GAME_SECONDS];

  state_e        r_state, w_state_n;
  bcd_t          r_tens, w_tens_n;
  bcd_t          r_ones, w_ones_n;
  bcd_t          r_time, w_time_n;
  logic [PW-1:0] r_presc, w_presc_n;
  logic          r_start_q, r_hit_q;
  logic          w_start_edge, w_hit_edge;
  logic          w_at_max;
  logic [6:0]    r_seg_tens, r_seg_ones, r_seg_time;
  logic [6:0]    w_seg_tens, w_seg_ones, w_seg_time;

  assign w_start_edge = iStart & ~r_start_q;
  assign w_hit_edge   = iHit & ~r_hit_q;
  assign w_at_max     = (r_tens == MAX_T) && (r_ones == MAX_O);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state   <= IDLE;
      r_tens    <= '0;
      r_ones    <= '0;
      r_time    <= T0;
      r_presc   <= '0;
      r_start_q <= 1'b0;
      r_hit_q   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_tens    <= w_tens_n;
      r_ones    <= w_ones_n;
      r_time    <= w_time_n;
      r_presc   <= w_presc_n;
      r_start_q <= iStart;
      r_hit_q   <= iHit;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_tens_n  = r_tens;
    w_ones_n  = r_ones;
    w_time_n  = r_time;
    w_presc_n = r_presc;
    unique case (r_state)
      IDLE, OVER: begin
        // a start edge here also swallows any coincident hit
        if (w_start_edge) begin
          w_state_n = RUN;
          w_tens_n  = '0;
          w_ones_n  = '0;
          w_time_n  = T0;
          w_presc_n = '0;
        end
      end
      RUN: begin
        if (w_hit_edge && !w_at_max) begin
          if (r_ones == 4'd9) begin
            w_ones_n = '0;
            w_tens_n = r_tens + 1'b1;
          end else begin
            w_ones_n = r_ones + 1'b1;
          end
        end
        if (r_presc == PRE_LAST) begin
          w_presc_n = '0;
          w_time_n  = r_time - 1'b1;
          if (r_time == 4'd1) w_state_n = OVER;
        end else begin
          w_presc_n = r_presc + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  seg7_encoder u_enc_tens (.i_bcd(r_tens), .o_seg(w_seg_tens));
  seg7_encoder u_enc_ones (.i_bcd(r_ones), .o_seg(w_seg_ones));
  seg7_encoder u_enc_time (.i_bcd(r_time), .o_seg(w_seg_time));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_seg_tens <= SEG_DIGIT[0];
      r_seg_ones <= SEG_DIGIT[0];
      r_seg_time <= SEG_T0;
    end else begin
      r_seg_tens <= w_seg_tens;
      r_seg_ones <= w_seg_ones;
      r_seg_time <= w_seg_time;
    end
  end

  assign oScore_tens = r_seg_tens;
  assign oScore_ones = r_seg_ones;
  assign oTime_seg   = r_seg_time;
  assign oScore_bcd  = {r_tens, r_ones};
  assign oRunning    = (r_state == RUN);
  assign oGameOver   = (r_state == OVER);

endmodule
